// File: rtl/srd_rst_pkg.sv
// Shared types and sizing helpers for the per-channel Ethernet reset scheduler.
package srd_rst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        HOLD_ST,
        RELEASE,
        DONE,
        ERR
    } state_e;

    // Counter must reach whichever of the hold / timeout limits is larger.
    function automatic int cnt_width(int hold_cycles, int timeout_cycles);
        return $clog2(((hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles) + 1);
    endfunction

    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/srd_rr_arb.sv
// Round-robin arbiter: combinational grant searching upward from the last
// winner, pointer advanced only when the grant is accepted.
module srd_rr_arb
    import srd_rst_pkg::*;
#(
    parameter int NUM_CHANNELS = 2
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [NUM_CHANNELS-1:0]                i_req,
    input  logic                                   i_accept,
    output logic                                   o_valid,
    output logic [NUM_CHANNELS-1:0]                o_gnt,
    output logic [idx_width(NUM_CHANNELS)-1:0]     o_idx
);

    localparam int IW = idx_width(NUM_CHANNELS);

    logic [IW-1:0] last_q;
    logic [IW-1:0] cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = last_q;
        o_gnt   = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            cand = IW'((int'(last_q) + k) % NUM_CHANNELS);
            if (!o_valid && i_req[cand]) begin
                o_valid = 1'b1;
                o_idx   = cand;
            end
        end
        if (o_valid) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

    // Resetting to the top index makes channel 0 the first winner.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= IW'(NUM_CHANNELS - 1);
        end else if (i_accept && o_valid) begin
            last_q <= o_idx;
        end
    end

endmodule

// File: rtl/srd_rst_sched.sv
// Serialises per-channel Ethernet IP reset handshakes, one channel at a time,
// round-robin, with per-channel timeout reporting.
module srd_rst_sched
    import srd_rst_pkg::*;
#(
    parameter int NUM_CHANNELS   = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_CHANNELS-1:0]            i_req,
    input  logic [NUM_CHANNELS-1:0]            i_rst_ack_n,
    input  logic                               i_err_clr,
    output logic [NUM_CHANNELS-1:0]            o_rst_n,
    output logic [NUM_CHANNELS-1:0]            o_done,
    output logic [NUM_CHANNELS-1:0]            o_timeout,
    output logic [NUM_CHANNELS-1:0]            o_err_sticky,
    output logic                               o_busy,
    output logic [idx_width(NUM_CHANNELS)-1:0] o_active_ch
);

    localparam int N  = NUM_CHANNELS;
    localparam int IW = idx_width(NUM_CHANNELS);
    localparam int CW = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] ch_q, ch_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  hold_q, hold_d;
    logic [N-1:0]  rst_n_q, rst_n_d;
    logic [N-1:0]  done_q, done_d;
    logic [N-1:0]  timeout_q, timeout_d;
    logic [N-1:0]  err_q, err_d;

    logic          arb_valid;
    logic [N-1:0]  arb_gnt;
    logic [IW-1:0] arb_idx;
    logic          accept;
    logic [N-1:0]  pend_clr;
    logic [N-1:0]  ch_oh;
    logic          ack_n;
    logic          drive;

    srd_rr_arb #(
        .NUM_CHANNELS(N)
    ) u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (pending_q),
        .i_accept(accept),
        .o_valid (arb_valid),
        .o_gnt   (arb_gnt),
        .o_idx   (arb_idx)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ch_oh[i] = (ch_q == IW'(i));
        end
    end

    assign ack_n = i_rst_ack_n[ch_q];

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        hold_d    = hold_q;
        done_d    = '0;
        timeout_d = '0;
        pend_clr  = '0;
        accept    = 1'b0;
        err_d     = err_q & ~{N{i_err_clr}};

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    accept   = 1'b1;
                    ch_d     = arb_idx;
                    pend_clr = arb_gnt;
                    cnt_d    = '0;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (!ack_n) begin
                    cnt_d   = '0;
                    state_d = HOLD_ST;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ERR;
                    hold_d    = hold_q & ~ch_oh;
                    timeout_d = ch_oh;
                    err_d     = err_d | ch_oh;
                end
            end
            HOLD_ST: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                    hold_d  = hold_q & ~ch_oh;
                end
            end
            RELEASE: begin
                if (ack_n) begin
                    state_d = DONE;
                    done_d  = ch_oh;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ERR;
                    hold_d    = hold_q & ~ch_oh;
                    timeout_d = ch_oh;
                    err_d     = err_d | ch_oh;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A request landing during the channel's own sequence re-arms it.
        pending_d = (pending_q & ~pend_clr) | i_req;

        drive = (state_d == ASSERT) || (state_d == HOLD_ST);
        for (int i = 0; i < N; i++) begin
            rst_n_d[i] = ~(hold_d[i] | (drive && (ch_d == IW'(i))));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            pending_q <= '1;
            hold_q    <= '1;
            rst_n_q   <= '0;
            done_q    <= '0;
            timeout_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
            rst_n_q   <= rst_n_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign o_rst_n      = rst_n_q;
    assign o_done       = done_q;
    assign o_timeout    = timeout_q;
    assign o_err_sticky = err_q;
    assign o_busy       = (state_q != IDLE);
    assign o_active_ch  = ch_q;

endmodule

// File: doc/srd_rst_sched.md
# srd_rst_sched

Per-channel Ethernet reset scheduler for the HSSI subsystem. Accepts reset requests from any of NUM_CHANNELS channels and serialises them, one channel at a time and round-robin, into each channel's active-low IP reset. Each reset is a full handshake: assert, wait for the IP acknowledge, hold, release, wait for the acknowledge to release. Timeout is reported per channel. It sits in the CSR clock domain, between the system reset requests and the Ethernet IP reset/ack pins.

## Interface
Parameters:
- NUM_CHANNELS, 2: number of Ethernet channels (≥1).
- HOLD_CYCLES, 16: cycles o_rst_n stays low after ack is seen (≥1).
- TIMEOUT_CYCLES, 1024: max cycles to wait for each ack edge (≥2).

Ports:
- i_clk  in  1  CSR clock; the only clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_req  in  NUM_CHANNELS  level reset request per channel; sampled every cycle, already synchronous to i_clk.
- i_rst_ack_n  in  NUM_CHANNELS  IP reset acknowledge, active-low, already synchronised to i_clk.
- i_err_clr  in  1  single-cycle pulse; clears o_err_sticky.
- o_rst_n  out  NUM_CHANNELS  registered IP reset, active-low.
- o_done  out  NUM_CHANNELS  one-cycle pulse when a channel sequence completes.
- o_timeout  out  NUM_CHANNELS  one-cycle pulse when a channel sequence times out.
- o_err_sticky  out  NUM_CHANNELS  set by timeout; cleared by i_err_clr.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_active_ch  out  max(1,$clog2(NUM_CHANNELS))  channel being sequenced; holds its last value in IDLE.

## Operation
- pending[N]: pending |= i_req each cycle. A bit clears when its channel is granted. A request for the active channel during its own sequence re-sets the bit, so the channel is re-run later.
- hold[N]: forced to all-ones by i_rst. hold[ch] clears when channel ch leaves HOLD_ST or enters ERR.
- o_rst_n[i] = ~(hold[i] | (i == ch && state ∈ {ASSERT, HOLD_ST})), registered.
- Arbitration: round-robin, searching upward from last_grant+1 with wrap. last_grant resets to NUM_CHANNELS-1, so channel 0 wins first.
- FSM:
  - IDLE: if any pending bit is set, latch ch = winner, clear pending[ch], clear the counter, go to ASSERT.
  - ASSERT: if i_rst_ack_n[ch] == 0, clear the counter and go to HOLD_ST. Else if the counter reaches TIMEOUT_CYCLES-1, go to ERR.
  - HOLD_ST: when the counter reaches HOLD_CYCLES-1, clear the counter and go to RELEASE.
  - RELEASE (o_rst_n[ch] = 1): if i_rst_ack_n[ch] == 1, go to DONE. Else on timeout, go to ERR.
  - DONE: o_done[ch] = 1, go to IDLE.
  - ERR: o_timeout[ch] = 1, set o_err_sticky[ch], go to IDLE. o_rst_n[ch] is released.
- If an i_err_clr pulse coincides with a timeout set, the set wins.
- One counter, width $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)+1), saturating.
- Reset state: state = IDLE, pending = all-ones, hold = all-ones. After reset, every channel is sequenced once, in order 0..N-1.
- Reset values of outputs: o_rst_n = 0, o_done = 0, o_timeout = 0, o_err_sticky = 0, o_busy = 0, o_active_ch = 0.
- i_rst asserted mid-sequence aborts immediately: all o_rst_n go low the next cycle and no o_done or o_timeout pulse is produced.

## Timing
- o_rst_n[ch] falls 2 cycles after i_req rises, if the FSM is idle: 1 cycle to capture into pending, 1 cycle for the grant.
- ACK-to-release latency is HOLD_CYCLES + 1 cycles from the first sampled i_rst_ack_n == 0 to o_rst_n = 1.
- o_done follows the sampled ack-high by 1 cycle. The FSM is back in IDLE the cycle after o_done, and the next grant happens in that IDLE cycle.
- Timeout fires after TIMEOUT_CYCLES sampled cycles without the ack edge.
- Simultaneous requests are served strictly one at a time, and no channel is granted twice while another is pending.

## Structure
- Package srd_rst_pkg: state enum (IDLE, ASSERT, HOLD_ST, RELEASE, DONE, ERR) and counter-width function.
- Sub-module srd_rr_arb (NUM_CHANNELS): round-robin pointer plus one-hot/index grant, combinational grant with registered pointer update on accept.

## Test plan
- Power-up, N=2, ack follows o_rst_n after 3 cycles: ch0 sequenced, o_done[0], then ch1, o_done[1]. Both o_rst_n end at 1, and neither rises before its own ack.
- i_req = 2'b11 in one cycle while idle: grants ch0 then ch1. A further i_req[0] during ch1 runs ch0 again after ch1, never ch0 twice back-to-back while ch1 is pending.
- Ack held at 1 throughout, TIMEOUT_CYCLES = 8: o_timeout[ch] pulses 8 cycles after ASSERT, o_err_sticky[ch] = 1, o_rst_n[ch] = 1. A later i_err_clr clears the sticky bit.
- Ack stuck low in RELEASE: timeout in RELEASE, ERR path, FSM returns to IDLE and serves the next pending channel.
- HOLD_CYCLES = 16: measure exactly 17 cycles from ack low sampled to o_rst_n high.
- i_rst pulsed mid-HOLD_ST: all o_rst_n = 0 the next cycle, no o_done; full power-up sequence restarts from ch0.
